// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-SRAM port between operand-fetch reads and write-stage writes,
// with a one-entry posted write buffer, read-after-write forwarding and a starvation limit.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we_n,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int STAGES = 2;
    localparam int AGE_W  = 4;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    typedef struct packed {
        logic                  fwd;
        logic [DATA_WIDTH-1:0] data;
    } rd_stage_t;

    buf_state_t            buf_state, buf_state_nxt;
    logic [ADDR_WIDTH-1:0] buf_addr;
    logic [DATA_WIDTH-1:0] buf_data;
    logic [AGE_W-1:0]      age;
    logic [STAGES:1]       vld_pipe;
    rd_stage_t             rd_s1;

    logic buf_full, forced, buf_hit, wr_match, fwd_wr, hit;
    logic port_read, drain;
    logic [DATA_WIDTH-1:0] fwd_data;

    always_ff @(posedge clk) begin
        if (!reset_n) buf_state <= BUF_EMPTY;
        else          buf_state <= buf_state_nxt;
    end

    // A full buffer whose address differs from the read only gets the write
    // forwarded once it is draining, so the tentative miss ignores wr_match then.
    always_comb begin
        buf_full      = (buf_state == BUF_FULL);
        forced        = buf_full && (age >= AGE_MAX);
        buf_hit       = buf_full && (buf_addr == rd_addr);
        wr_match      = wr_req && (wr_addr == rd_addr);
        port_read     = rd_req && !forced && !buf_hit && !(wr_match && !buf_full);
        drain         = buf_full && !port_read;
        wr_gnt        = wr_req && (!buf_full || drain);
        fwd_wr        = wr_match && wr_gnt;
        hit           = fwd_wr || buf_hit;
        rd_gnt        = port_read || (rd_req && hit);
        fwd_data      = fwd_wr ? wr_data : buf_data;
        buf_state_nxt = buf_state;
        if (wr_gnt)     buf_state_nxt = BUF_FULL;
        else if (drain) buf_state_nxt = BUF_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_addr <= '0;
            buf_data <= '0;
            age      <= '0;
        end else if (wr_gnt) begin
            buf_addr <= wr_addr;
            buf_data <= wr_data;
            age      <= '0;
        end else if (buf_full && !drain && age < AGE_MAX) begin
            age <= age + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we_n  <= 1'b1;
        end else if (port_read) begin
            mem_addr  <= rd_addr;
            mem_we_n  <= 1'b1;
        end else if (drain) begin
            mem_addr  <= buf_addr;
            mem_wdata <= buf_data;
            mem_we_n  <= 1'b0;
        end else begin
            mem_we_n  <= 1'b1;
        end
    end

    // Hits are delayed to match the SRAM path so every read returns two cycles after grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            rd_s1    <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:1], rd_gnt};
            rd_s1.fwd  <= rd_gnt && !port_read;
            rd_s1.data <= fwd_data;
            if (vld_pipe[1])
                rd_data <= rd_s1.fwd ? rd_s1.data : mem_rdata;
        end
    end

    assign rd_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: SRAM model, shadow-memory scoreboard for read data and
// latency, table of per-cycle grant/write-port vectors, and directed corner sequences.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_req, wr_req;
    logic [15:0] rd_addr, wr_addr, wr_data;
    logic        rd_gnt, wr_gnt, rd_valid, mem_we_n;
    logic [15:0] rd_data, mem_addr, mem_wdata, mem_rdata;

    dmem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we_n(mem_we_n),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] sram   [256];
    logic [15:0] shadow [256];
    int          wr30_cnt = 0;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    assign mem_rdata = sram[mem_addr[7:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_we_n) begin
            sram[mem_addr[7:0]] <= mem_wdata;
            if (mem_addr == 16'h0030) wr30_cnt <= wr30_cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    // Response monitor: every rd_valid must match the oldest granted read, on its due cycle.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else if (rd_valid) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%h, required no response (cycle %0d)", rd_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rd_data !== e.data || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL rd_resp: got data=%h at cycle %0d, required data=%h at cycle %0d", rd_data, cyc, e.data, e.due);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_assert++;
            n_fail++;
            $display("FAIL rd_resp_missing: got no rd_valid at cycle %0d, required data=%h", cyc, e.data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle's requests, let combinational grants settle, update the model.
    task automatic drive(input logic rr, input logic [15:0] ra,
                         input logic wr, input logic [15:0] wa, input logic [15:0] wd);
        rd_req = rr; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
        #2;
        if (wr_gnt) shadow[wa[7:0]] = wd;
        if (rd_gnt) exp_q.push_back('{data: shadow[ra[7:0]], due: cyc + 2});
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    typedef struct {
        logic        rr;
        logic [15:0] ra;
        logic        wr;
        logic [15:0] wa;
        logic [15:0] wd;
        logic        e_rg;
        logic        e_wg;
        logic        e_we_n;
        logic [15:0] e_maddr;
    } vec_t;
    vec_t tbl[15];

    initial begin
        // Buffer forward + write stall, then starvation drain (limit 4).
        tbl[0]  = '{1'b1, 16'h0040, 1'b1, 16'h0020, 16'h5AA5, 1'b1, 1'b1, 1'b1, 16'h0000};
        tbl[1]  = '{1'b1, 16'h0041, 1'b1, 16'h0050, 16'h0777, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[2]  = '{1'b1, 16'h0042, 1'b1, 16'h0050, 16'h0777, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[3]  = '{1'b1, 16'h0020, 1'b1, 16'h0050, 16'h0777, 1'b1, 1'b1, 1'b1, 16'h0000};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0020};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0050};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[7]  = '{1'b1, 16'h0060, 1'b1, 16'h0070, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h0000};
        tbl[8]  = '{1'b1, 16'h0061, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[9]  = '{1'b1, 16'h0062, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[10] = '{1'b1, 16'h0063, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[11] = '{1'b1, 16'h0064, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[12] = '{1'b1, 16'h0065, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[13] = '{1'b1, 16'h0065, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0070};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};

        for (int i = 0; i < 256; i++) begin
            sram[i]   = {i[7:0], i[7:0]};
            shadow[i] = {i[7:0], i[7:0]};
        end

        reset_n = 1'b0;
        rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("reset_mem_we_n", 32'(mem_we_n), 32'h1);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        reset_n = 1'b1;
        nxt();

        // Single write, drain, then read back from SRAM.
        drive(1'b0, 16'h0, 1'b1, 16'h0010, 16'h1234);
        chk("t1_wr_gnt", 32'(wr_gnt), 32'h1);
        chk("t1_rd_gnt_idle", 32'(rd_gnt), 32'h0);
        nxt();
        idle();
        chk("t1_we_n_load", 32'(mem_we_n), 32'h1);
        nxt();
        idle();
        chk("t1_we_n_drain", 32'(mem_we_n), 32'h0);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        chk("t1_mem_wdata", 32'(mem_wdata), 32'h1234);
        nxt();
        drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
        chk("t1_rd_gnt", 32'(rd_gnt), 32'h1);
        chk("t1_we_n_after", 32'(mem_we_n), 32'h1);
        nxt();
        idle(); nxt();
        idle();
        chk("t1_rd_valid", 32'(rd_valid), 32'h1);
        chk("t1_rd_data", 32'(rd_data), 32'h1234);
        nxt();

        // Same-cycle read-after-write forward, no SRAM read of 0x0020.
        drive(1'b1, 16'h0020, 1'b1, 16'h0020, 16'h00AA);
        chk("t2_rd_gnt", 32'(rd_gnt), 32'h1);
        chk("t2_wr_gnt", 32'(wr_gnt), 32'h1);
        nxt();
        idle();
        chk("t2_no_sram_read_we_n", 32'(mem_we_n), 32'h1);
        chk("t2_no_sram_read_addr", 32'(mem_addr), 32'h0010);
        nxt();
        idle();
        chk("t2_rd_valid", 32'(rd_valid), 32'h1);
        chk("t2_rd_data", 32'(rd_data), 32'h00AA);
        chk("t2_drain_we_n", 32'(mem_we_n), 32'h0);
        chk("t2_drain_addr", 32'(mem_addr), 32'h0020);
        chk("t2_drain_wdata", 32'(mem_wdata), 32'h00AA);
        nxt();
        idle();
        chk("t2_we_n_release", 32'(mem_we_n), 32'h1);
        nxt();

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rr, tbl[i].ra, tbl[i].wr, tbl[i].wa, tbl[i].wd);
            chk($sformatf("vec%0d_rd_gnt", i), 32'(rd_gnt), 32'(tbl[i].e_rg));
            chk($sformatf("vec%0d_wr_gnt", i), 32'(wr_gnt), 32'(tbl[i].e_wg));
            chk($sformatf("vec%0d_we_n", i), 32'(mem_we_n), 32'(tbl[i].e_we_n));
            if (!tbl[i].e_we_n)
                chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_maddr));
            nxt();
        end

        // Back-to-back reads stream out in grant order.
        drive(1'b1, 16'h0001, 1'b0, 16'h0, 16'h0);
        chk("b2b_gnt0", 32'(rd_gnt), 32'h1);
        nxt();
        drive(1'b1, 16'h0002, 1'b0, 16'h0, 16'h0);
        chk("b2b_gnt1", 32'(rd_gnt), 32'h1);
        nxt();
        drive(1'b1, 16'h0003, 1'b0, 16'h0, 16'h0);
        chk("b2b_gnt2", 32'(rd_gnt), 32'h1);
        chk("b2b_valid0", 32'(rd_valid), 32'h1);
        chk("b2b_data0", 32'(rd_data), 32'h0101);
        nxt();
        idle();
        chk("b2b_valid1", 32'(rd_valid), 32'h1);
        chk("b2b_data1", 32'(rd_data), 32'h0202);
        nxt();
        idle();
        chk("b2b_valid2", 32'(rd_valid), 32'h1);
        chk("b2b_data2", 32'(rd_data), 32'h0303);
        nxt();
        idle();
        chk("b2b_valid_end", 32'(rd_valid), 32'h0);
        nxt();

        // Reset while a write sits buffered behind reads and reads are in flight.
        drive(1'b1, 16'h0080, 1'b1, 16'h0030, 16'h0055);
        chk("rst_wr_gnt", 32'(wr_gnt), 32'h1);
        nxt();
        drive(1'b1, 16'h0081, 1'b0, 16'h0, 16'h0);
        chk("rst_rd_gnt1", 32'(rd_gnt), 32'h1);
        nxt();
        drive(1'b1, 16'h0082, 1'b0, 16'h0, 16'h0);
        chk("rst_rd_gnt2", 32'(rd_gnt), 32'h1);
        nxt();
        reset_n = 1'b0;
        idle();
        chk("rst_we_n_pre", 32'(mem_we_n), 32'h1);
        nxt();
        reset_n = 1'b1;
        shadow[8'h30] = 16'h3030;
        idle();
        chk("rst_we_n_post", 32'(mem_we_n), 32'h1);
        chk("rst_rd_valid_post", 32'(rd_valid), 32'h0);
        chk("rst_mem_addr_post", 32'(mem_addr), 32'h0);
        nxt();
        drive(1'b1, 16'h0084, 1'b1, 16'h0031, 16'h0066);
        chk("rst_buf_empty_wr_gnt", 32'(wr_gnt), 32'h1);
        chk("rst_buf_empty_rd_gnt", 32'(rd_gnt), 32'h1);
        chk("rst_inflight_dropped", 32'(rd_valid), 32'h0);
        chk("rst_we_n_c5", 32'(mem_we_n), 32'h1);
        nxt();
        idle(); nxt();
        idle();
        chk("rst_new_drain_we_n", 32'(mem_we_n), 32'h0);
        chk("rst_new_drain_addr", 32'(mem_addr), 32'h0031);
        nxt();
        repeat (4) begin idle(); nxt(); end

        chk("rst_no_write_0030", 32'(wr30_cnt), 32'h0);
        chk("rst_sram_0030", 32'(sram[8'h30]), 32'h3030);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
